uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receive-side counterpart of the UART transmit serializer. Recovers one asynchronous UART frame (start, DATA_LENGTH data bits LSB-first, optional parity, one stop bit) from an oversampled serial line. Presents the word in parallel with a one-cycle valid pulse. Sits between the RX line synchronizer and the system control / RX CDC path.

## Interface
- DATA_LENGTH, 8, data bits per frame
- PRESCALE_WIDTH, 6, width of the oversampling ratio input
- CLK  input  1  oversampling clock, equal to baud rate × Prescale
- RST  input  1  asynchronous, active-high reset
- RX_IN  input  1  serial line, already synchronized to CLK, idle high
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; supported values 8, 16, 32
- PAR_EN  input  1  1 = parity bit present
- PAR_TYP  input  1  0 = even, 1 = odd
- P_DATA  output  DATA_LENGTH  last good received word
- Data_Valid  output  1  one-cycle pulse when P_DATA is updated
- Parity_Error  output  1  one-cycle pulse on parity mismatch
- Stop_Error  output  1  one-cycle pulse on a low stop bit

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Edge counter: counts 0..Prescale-1 within each bit and wraps to 0. Bit counter: counts data bits 0..DATA_LENGTH-1.
- Prescale, PAR_EN and PAR_TYP are latched on start detection. Changes mid-frame have no effect.
- IDLE -> START when RX_IN = 0. That cycle is edge 0 of the start bit.
- Sampling: majority of 3 samples taken at edges Prescale/2-1, Prescale/2, Prescale/2+1. The bit value is resolved at edge Prescale/2+1.
- START: if the resolved value is 1, the start is a glitch: return to IDLE at edge Prescale-1 with no outputs. Otherwise go to DATA at the wrap.
- DATA: shift the resolved bit into the shift register LSB-first. After DATA_LENGTH bits, go to PARITY if PAR_EN = 1, else STOP.
- PARITY: expected bit = XOR of the data bits, XOR PAR_TYP. On mismatch, set a frame-error flag and pulse Parity_Error at the parity-bit wrap. Always continue to STOP.
- STOP: at the wrap, return to IDLE.
  - Resolved 0: pulse Stop_Error.
  - Resolved 1 with no parity error: load P_DATA and pulse Data_Valid.
  - Any error: P_DATA unchanged.
- P_DATA holds its value between frames and is never cleared except by reset.

## Timing
- Reset values: P_DATA = 0, Data_Valid = 0, Parity_Error = 0, Stop_Error = 0, FSM = IDLE, counters = 0.
- Frame length: (2 + DATA_LENGTH + PAR_EN) × Prescale cycles from the start-detect cycle.
- Data_Valid, Parity_Error and Stop_Error are registered. Each is high exactly one cycle: the cycle after the wrap edge that produces it.
- Data_Valid latency: the frame-length cycles after the start-detect cycle.
- Back-to-back frames: RX_IN = 0 in the first IDLE cycle after STOP starts the next frame. No dead cycle is required beyond that.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. A partial frame produces no pulse.
- Parity_Error and Stop_Error may both pulse for the same frame, in separate cycles.

## Structure
- Shared package uart_pkg holds:
  - the FSM state encoding (typedef, 3-bit)
  - PAR_EVEN = 0 and PAR_ODD = 1
  - supported prescale constants 8, 16, 32
- One sub-module: uart_rx_sampler.
  - Inputs: RX_IN, edge counter, Prescale.
  - Outputs: the resolved bit and a bit-ready strobe.
  - Implements the 3-sample majority vote.
- FSM, counters, shift register and parity check live in the top module.

## Test plan
- 8N1, Prescale 8, send 0xA5: Data_Valid pulses once, 80 cycles after the start-detect cycle, with P_DATA = 0xA5. No error pulses.
- Even parity, Prescale 16, send 0x3C with parity bit 0: P_DATA = 0x3C, Data_Valid at cycle 176. Repeat with odd parity and parity bit 1: same result.
- Even parity, send 0x01 with parity bit 0: Parity_Error pulses at the parity wrap. Data_Valid is never asserted and P_DATA keeps its previous value.
- Stop bit driven low, 0x55, Prescale 32: Stop_Error pulses once, no Data_Valid. A following good frame 0x0F is received correctly.
- RX_IN low for 2 cycles then high, Prescale 8: FSM returns to IDLE, no pulses. A genuine frame 0xC3 immediately after is received.
- Reset asserted at data bit 4 of 0xFF: all outputs return to 0 at once. Release, then send 0x81: P_DATA = 0x81 with one Data_Valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_pkg                                                              |
// | Shared types and constants for the UART receive path.                 |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx_sampler                                                       |
// | Three-sample majority vote around the middle of each bit period.      |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_val,
  output logic                      bit_ready
);

  logic                      s0_q, s0_d;
  logic                      s1_q, s1_d;
  logic [PRESCALE_WIDTH-1:0] half;

  assign half = prescale >> 1;

  always_comb begin
    s0_d      = s0_q;
    s1_d      = s1_q;
    bit_ready = 1'b0;
    bit_val   = 1'b0;
    if (edge_cnt == half - 1'b1) s0_d = rx_in;
    if (edge_cnt == half)        s1_d = rx_in;
    // Third sample is taken live, so the vote resolves on this edge.
    if (edge_cnt == half + 1'b1) begin
      bit_ready = 1'b1;
      bit_val   = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx_deserializer                                                  |
// | Recovers one oversampled UART frame and presents the word in parallel.|
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH    = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_LENGTH-1:0]    P_DATA,
  output logic                      Data_Valid,
  output logic                      Parity_Error,
  output logic                      Stop_Error
);

  localparam int BCW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

  rx_state_e                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_LENGTH-1:0]    shift_q, shift_d;
  logic [DATA_LENGTH-1:0]    p_data_q, p_data_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      bit_q, bit_d;
  logic                      frame_err_q, frame_err_d;
  logic                      dv_q, dv_d;
  logic                      pe_q, pe_d;
  logic                      se_q, se_d;

  logic smp_bit;
  logic smp_ready;
  logic wrap;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .rx_in    (RX_IN),
    .edge_cnt (edge_q),
    .prescale (presc_q),
    .bit_val  (smp_bit),
    .bit_ready(smp_ready)
  );

  assign wrap = (edge_q == presc_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    p_data_d    = p_data_q;
    presc_d     = presc_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    bit_d       = bit_q;
    frame_err_d = frame_err_q;
    dv_d        = 1'b0;
    pe_d        = 1'b0;
    se_d        = 1'b0;

    if (state_q != IDLE) edge_d = wrap ? '0 : edge_q + 1'b1;
    if (smp_ready)       bit_d  = smp_bit;

    case (state_q)
      IDLE: begin
        edge_d = '0;
        // Start-detect cycle counts as edge 0, so the counter resumes at 1.
        if (!RX_IN) begin
          state_d     = START;
          edge_d      = PRESCALE_WIDTH'(1);
          bit_cnt_d   = '0;
          presc_d     = Prescale;
          par_en_d    = PAR_EN;
          par_typ_d   = PAR_TYP;
          frame_err_d = 1'b0;
        end
      end
      START: begin
        if (wrap) state_d = bit_q ? IDLE : DATA;
      end
      DATA: begin
        if (wrap) begin
          shift_d = {bit_q, shift_q[DATA_LENGTH-1:1]};
          if (bit_cnt_q == BCW'(DATA_LENGTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (wrap) begin
          if (bit_q != ((^shift_q) ^ par_typ_q)) begin
            frame_err_d = 1'b1;
            pe_d        = 1'b1;
          end
          state_d = STOP;
        end
      end
      STOP: begin
        if (wrap) begin
          state_d = IDLE;
          if (!bit_q) begin
            se_d = 1'b1;
          end else if (!frame_err_q) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      edge_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      p_data_q    <= '0;
      presc_q     <= PRESCALE_WIDTH'(PRESCALE_8);
      par_en_q    <= 1'b0;
      par_typ_q   <= PAR_EVEN;
      bit_q       <= 1'b1;
      frame_err_q <= 1'b0;
      dv_q        <= 1'b0;
      pe_q        <= 1'b0;
      se_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      p_data_q    <= p_data_d;
      presc_q     <= presc_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      bit_q       <= bit_d;
      frame_err_q <= frame_err_d;
      dv_q        <= dv_d;
      pe_q        <= pe_d;
      se_q        <= se_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = dv_q;
  assign Parity_Error = pe_q;
  assign Stop_Error   = se_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_rx_deserializer                                               |
// | Directed frames against hand-computed words, pulses and latencies.    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_uart_rx_deserializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
  logic [7:0] dv_data = '0;

  uart_rx_deserializer #(
    .DATA_LENGTH(8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .Parity_Error(Parity_Error),
    .Stop_Error  (Stop_Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_cyc  <= cyc;
      dv_data <= P_DATA;
    end
    if (Parity_Error) begin
      pe_cnt <= pe_cnt + 1;
      pe_cyc <= cyc;
    end
    if (Stop_Error) begin
      se_cnt <= se_cnt + 1;
      se_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // abort_bit < 0 sends the whole frame; otherwise stops before that bit index.
  task automatic send_frame(input logic [7:0] data, input int presc, input bit par_en,
                            input bit par_typ, input bit par_bit, input bit stop_bit,
                            input int abort_bit, output int t0);
    logic bits [0:10];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (par_en) begin
      bits[nb] = par_bit;
      nb++;
    end
    bits[nb] = stop_bit;
    nb++;
    @(negedge CLK);
    Prescale = 6'(presc);
    PAR_EN   = par_en;
    PAR_TYP  = par_typ;
    t0       = cyc;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_bit) return;
      RX_IN = bits[i];
      repeat (presc) @(negedge CLK);
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    int t0;
    int dv0, pe0, se0;

    #1;
    chk("reset_pdata", 32'(P_DATA), 32'h0);
    chk("reset_dv", 32'(Data_Valid), 32'h0);
    chk("reset_pe", 32'(Parity_Error), 32'h0);
    chk("reset_se", 32'(Stop_Error), 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // 8N1, prescale 8, 0xA5
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    repeat (4) @(negedge CLK);
    chk("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("a5_latency", 32'(dv_cyc - t0), 32'd80);
    chk("a5_data", 32'(dv_data), 32'hA5);
    chk("a5_pdata_hold", 32'(P_DATA), 32'hA5);
    chk("a5_no_err", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

    // Even parity, prescale 16, 0x3C with parity 0
    dv0 = dv_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, t0);
    repeat (4) @(negedge CLK);
    chk("3c_even_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("3c_even_latency", 32'(dv_cyc - t0), 32'd176);
    chk("3c_even_data", 32'(dv_data), 32'h3C);

    // Odd parity, 0x3C with parity 1
    dv0 = dv_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, t0);
    repeat (4) @(negedge CLK);
    chk("3c_odd_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("3c_odd_latency", 32'(dv_cyc - t0), 32'd176);
    chk("3c_odd_data", 32'(dv_data), 32'h3C);
    chk("3c_no_err", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

    // Even parity, 0x01 with wrong parity bit 0
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h01, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, t0);
    repeat (4) @(negedge CLK);
    chk("perr_count", 32'(pe_cnt - pe0), 32'd1);
    chk("perr_latency", 32'(pe_cyc - t0), 32'd160);
    chk("perr_no_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("perr_no_se", 32'(se_cnt - se0), 32'd0);
    chk("perr_pdata_kept", 32'(P_DATA), 32'h3C);

    // Low stop bit, prescale 32, 0x55, then good 0x0F
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, t0);
    repeat (4) @(negedge CLK);
    chk("serr_count", 32'(se_cnt - se0), 32'd1);
    chk("serr_latency", 32'(se_cyc - t0), 32'd320);
    chk("serr_no_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("serr_pdata_kept", 32'(P_DATA), 32'h3C);
    dv0 = dv_cnt;
    send_frame(8'h0F, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    repeat (4) @(negedge CLK);
    chk("0f_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("0f_latency", 32'(dv_cyc - t0), 32'd320);
    chk("0f_data", 32'(dv_data), 32'h0F);
    chk("0f_no_err", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd1);

    // Two-cycle glitch then 0xC3 starting in the first IDLE cycle
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    @(negedge CLK);
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    chk("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    repeat (4) @(negedge CLK);
    chk("c3_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("c3_latency", 32'(dv_cyc - t0), 32'd80);
    chk("c3_data", 32'(dv_data), 32'hC3);
    chk("c3_no_err", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

    // Reset during data bit 4 of 0xFF, then 0x81
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 5, t0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_mid_pdata", 32'(P_DATA), 32'h0);
    chk("rst_mid_dv", 32'(Data_Valid), 32'h0);
    chk("rst_mid_pe", 32'(Parity_Error), 32'h0);
    chk("rst_mid_se", 32'(Stop_Error), 32'h0);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_partial_no_pulse", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    repeat (4) @(negedge CLK);
    chk("81_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("81_latency", 32'(dv_cyc - t0), 32'd80);
    chk("81_data", 32'(P_DATA), 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
